// File: rtl/disp_pkg.sv
// Shared types and constants for the display render scheduler.
package disp_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_SWAP  = 2'd3
    } state_t;

    localparam int unsigned TIMEOUT_DEF = 2**20;

    // Stage index width; a single-stage build still needs one bit.
    function automatic int stage_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disp_render_sched_if.sv
// Scheduler <-> renderer/display bundle; master is the scheduler side.
interface disp_render_sched_if #(
    parameter int N  = 3,
    parameter int FW = 16
);
    logic          enable;
    logic          vblank;
    logic          err_clr;
    logic          stat;
    logic          busy;
    logic [N-1:0]  start;
    logic [N-1:0]  done;
    logic [N-1:0]  err;
    logic [FW-1:0] frame_cnt;

    modport master (
        input  enable, vblank, done, err_clr,
        output start, stat, busy, frame_cnt, err
    );

    modport slave (
        output enable, vblank, done, err_clr,
        input  start, stat, busy, frame_cnt, err
    );

endinterface

// File: rtl/disp_watchdog.sv
// Per-stage hang detector: counts cycles while run is high and pulses expire
// on the cycle the count reaches TIMEOUT-1. TIMEOUT=0 disables it.
module disp_watchdog
    import disp_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clkSYS,
    input  logic reset,
    input  logic clr,
    input  logic run,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_wd;
            assign unused_wd = &{1'b0, clkSYS, reset, clr, run};
            assign expire    = 1'b0;
        end else begin : g_on
            localparam int            CW    = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);
            localparam logic [CW-1:0] SAT   = CW'(TIMEOUT);

            logic [CW-1:0] cnt;

            // Saturating one past LIMIT keeps expire to a single cycle.
            always_ff @(posedge clkSYS or posedge reset) begin
                if (reset) begin
                    cnt <= '0;
                end else if (clr) begin
                    cnt <= '0;
                end else if (run && (cnt != SAT)) begin
                    cnt <= cnt + CW'(1);
                end
            end

            assign expire = run && !clr && (cnt == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/disp_render_sched.sv
// Frame scheduler: starts renderer stages in order, waits on each done (or a
// watchdog expiry), then flips the render/display buffer on the next vblank.
module disp_render_sched
    import disp_pkg::*;
#(
    parameter int          N       = 3,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF,
    parameter int          FW      = 16
) (
    input  logic                clkSYS,
    input  logic                reset,
    disp_render_sched_if.master bus
);

    localparam int            SW       = stage_w(N);
    localparam logic [N-1:0]  ONE_HOT0 = N'(1);
    localparam logic [SW-1:0] LAST_IDX = SW'(N - 1);

    state_t        state;
    logic [SW-1:0] idx;
    logic [N-1:0]  start_r;
    logic [N-1:0]  err_r;
    logic          stat_r;
    logic          busy_r;
    logic [FW-1:0] frame_cnt_r;

    logic          wd_clr;
    logic          wd_run;
    logic          wd_expire;
    logic          done_hit;

    assign wd_clr   = (state == S_START);
    assign wd_run   = (state == S_WAIT);
    assign done_hit = bus.done[idx];

    disp_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clkSYS (clkSYS),
        .reset  (reset),
        .clr    (wd_clr),
        .run    (wd_run),
        .expire (wd_expire)
    );

    always_ff @(posedge clkSYS or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            idx         <= '0;
            start_r     <= '0;
            err_r       <= '0;
            stat_r      <= 1'b0;
            busy_r      <= 1'b0;
            frame_cnt_r <= '0;
        end else begin
            start_r <= '0;
            // A clear followed by a new timeout below leaves only the new bit.
            if (bus.err_clr) begin
                err_r <= '0;
            end

            unique case (state)
                S_IDLE: begin
                    if (bus.enable) begin
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= S_START;
                    end
                end

                S_START: begin
                    start_r <= ONE_HOT0 << idx;
                    state   <= S_WAIT;
                end

                S_WAIT: begin
                    // done beats a simultaneous expiry, so no error is logged.
                    if (done_hit || wd_expire) begin
                        if (!done_hit) begin
                            err_r[idx] <= 1'b1;
                        end
                        if (idx == LAST_IDX) begin
                            state <= S_SWAP;
                        end else begin
                            idx   <= idx + SW'(1);
                            state <= S_START;
                        end
                    end
                end

                S_SWAP: begin
                    if (bus.vblank) begin
                        stat_r      <= ~stat_r;
                        frame_cnt_r <= frame_cnt_r + FW'(1);
                        busy_r      <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.start     = start_r;
    assign bus.err       = err_r;
    assign bus.stat      = stat_r;
    assign bus.busy      = busy_r;
    assign bus.frame_cnt = frame_cnt_r;

endmodule
